// File: rtl/light_hash_pkg.sv
// Shared constants, state encoding and character classifier for light_hash.
package light_hash_pkg;

  localparam logic [63:0] IV_DEFAULT = 64'h34550F14DAC02BEE;

  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_UA  = 8'h41;
  localparam logic [7:0] CH_UZ  = 8'h5A;
  localparam logic [7:0] CH_LA  = 8'h61;
  localparam logic [7:0] CH_LZ  = 8'h7A;

  typedef enum logic {IDLE, BUSY} state_e;

  // Alphanumeric ASCII only; NUL is handled separately as the terminator.
  function automatic logic is_valid_char(input logic [7:0] c);
    return (c >= CH_0  && c <= CH_9 ) ||
           (c >= CH_UA && c <= CH_UZ) ||
           (c >= CH_LA && c <= CH_LZ);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a combinational 256-entry lookup.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y_o = SBOX[a_i];

endmodule

// File: rtl/light_hash.sv
// Byte-serial hash: each accepted character is mixed into the 8-byte state
// with one S-box lookup per cycle, ROUNDS passes over all 8 bytes.
module light_hash
  import light_hash_pkg::*;
#(
  parameter int          ROUNDS = 4,
  parameter logic [63:0] IV     = IV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,       // active-high synchronous reset despite the name
  input  logic [7:0]  ptxt_char,
  input  logic        ptxt_valid,
  output logic [63:0] digest_char,
  output logic        digest_ready,
  output logic        err_invalid_ptxt_char
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_e          state_q, state_d;
  logic [0:7][7:0] h_q, h_d;       // h_q[0] is the MSB byte of the digest
  logic [7:0]      m_q, m_d;
  logic [2:0]      j_q, j_d;
  logic [RW-1:0]   r_q, r_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            next_byte;

  logic [2:0]      j_src;
  logic [7:0]      sbox_in, sbox_out, h_rot;

  // Operand byte two positions ahead, wrapping modulo 8 via the 3-bit add.
  assign j_src   = j_q + 3'd2;
  assign sbox_in = h_q[j_src] ^ m_q;
  assign h_rot   = {h_q[j_q][6:0], h_q[j_q][7]};

  aes_sbox u_sbox (
    .a_i (sbox_in),
    .y_o (sbox_out)
  );

  // Next-state: accept/classify characters in IDLE, mix one byte per cycle in BUSY.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    j_d     = j_q;
    r_d     = r_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ptxt_valid) begin
          if (is_valid_char(ptxt_char)) begin
            // A published digest means the next character starts a new message.
            if (ready_q) h_d = IV;
            m_d     = ptxt_char;
            j_d     = 3'd0;
            r_d     = '0;
            ready_d = 1'b0;
            state_d = BUSY;
          end else if (ptxt_char == CH_NUL) begin
            ready_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        h_d[j_q] = sbox_out ^ h_rot;
        j_d      = j_q + 3'd1;
        if (j_q == 3'd7) begin
          r_d = r_q + RW'(1);
          if (r_q == RW'(ROUNDS - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset overriding any in-flight byte.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      h_q     <= IV;
      m_q     <= '0;
      j_q     <= '0;
      r_q     <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      j_q     <= j_d;
      r_q     <= r_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign next_byte             = (state_q == BUSY);
  assign digest_char           = h_q;
  assign digest_ready          = ready_q;
  assign err_invalid_ptxt_char = err_q;

endmodule

// File: tb/tb_light_hash.sv
// Randomized bench for light_hash against a transaction-level model whose
// S-box is derived from GF(2^8) inversion plus the AES affine map.
module tb_light_hash;

  localparam logic [63:0] IV_C = 64'h34550F14DAC02BEE;
  localparam int          LAT  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  ptxt_char = 8'h00;
  logic        ptxt_valid = 1'b0;
  logic [63:0] digest_char;
  logic        digest_ready;
  logic        err_invalid_ptxt_char;

  light_hash dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ptxt_char             (ptxt_char),
    .ptxt_valid            (ptxt_valid),
    .digest_char           (digest_char),
    .digest_ready          (digest_ready),
    .err_invalid_ptxt_char (err_invalid_ptxt_char)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [7:0] mh [8];
  logic       exp_ready = 1'b0;
  logic       exp_err   = 1'b0;
  logic       exp_busy  = 1'b0;
  logic       chk_en    = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] base = x;
    int e = 254;
    if (x == 8'h00) inv = 8'h00;
    else begin
      while (e > 0) begin
        if (e % 2 == 1) inv = gmul(inv, base);
        base = gmul(base, base);
        e = e / 2;
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic is_alnum(input logic [7:0] c);
    return c inside {[8'h30:8'h39], [8'h41:8'h5A], [8'h61:8'h7A]};
  endfunction

  function automatic logic [63:0] model_digest();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[63-8*i -: 8] = mh[i];
    return d;
  endfunction

  task automatic model_load_iv();
    for (int i = 0; i < 8; i++) mh[i] = IV_C[63-8*i -: 8];
  endtask

  task automatic model_absorb(input logic [7:0] m);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 8; j++)
        mh[j] = ref_sbox(mh[(j + 2) % 8] ^ m) ^ rotl8(mh[j], 1);
  endtask

  task automatic model_reset();
    model_load_iv();
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    exp_busy  = 1'b0;
  endtask

  // Per-cycle compare against model expectations, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_busy) begin
        chk("next_byte_busy", 64'(dut.next_byte), 64'd1);
        chk("ready_busy", 64'(digest_ready), 64'd0);
        chk("err_busy", 64'(err_invalid_ptxt_char), 64'd0);
      end else begin
        chk("next_byte_idle", 64'(dut.next_byte), 64'd0);
        chk("digest", digest_char, model_digest());
        chk("ready", 64'(digest_ready), 64'(exp_ready));
        chk("err", 64'(err_invalid_ptxt_char), 64'(exp_err));
      end
    end
  end

  // Offer one character; abort_at >= 1 asserts reset that many cycles into a byte.
  task automatic offer(input logic [7:0] c, input int abort_at);
    bit done = 0;
    @(posedge clk); #1;
    ptxt_char  = c;
    ptxt_valid = 1'b1;
    @(posedge clk); #1;
    ptxt_valid = 1'b0;
    if (is_alnum(c)) begin
      if (exp_ready) model_load_iv();
      exp_ready = 1'b0;
      exp_busy  = 1'b1;
      model_absorb(c);
      for (int k = 1; k <= LAT && !done; k++) begin
        @(posedge clk); #1;
        if (k == abort_at) begin
          rst_n      = 1'b1;
          ptxt_valid = 1'b0;
        end else if (k == abort_at + 1) begin
          rst_n = 1'b0;
          model_reset();
          done = 1;
        end else if (k < LAT) begin
          // Traffic during mixing must be ignored, including NULs and junk.
          ptxt_valid = 1'($urandom_range(0, 1));
          ptxt_char  = 8'($urandom);
        end else begin
          ptxt_valid = 1'b0;
          exp_busy   = 1'b0;
        end
      end
    end else if (c == 8'h00) begin
      exp_ready = 1'b1;
    end else begin
      exp_err = 1'b1;
      @(posedge clk); #1;
      exp_err = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string       alnum = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";
    logic [63:0] d_a;
    logic [7:0]  rc;
    int          sel;

    // Pin the reference S-box to known AES values.
    chk("sbox_00", 64'(ref_sbox(8'h00)), 64'h63);
    chk("sbox_53", 64'(ref_sbox(8'h53)), 64'hED);
    chk("sbox_01", 64'(ref_sbox(8'h01)), 64'h7C);
    chk("sbox_ff", 64'(ref_sbox(8'hFF)), 64'h16);

    // Reset and idle
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_digest", digest_char, IV_C);
    chk("rst_ready", 64'(digest_ready), 64'd0);

    // Invalid char: one-cycle error, state untouched
    offer(8'hFF, -1);
    chk("inv_digest", digest_char, IV_C);
    chk("inv_err_cleared", 64'(err_invalid_ptxt_char), 64'd0);

    // Empty message yields IV
    offer(8'h00, -1);
    chk("empty_ready", 64'(digest_ready), 64'd1);
    chk("empty_digest", digest_char, IV_C);
    offer(8'h00, -1);
    chk("nul_again_ready", 64'(digest_ready), 64'd1);

    // Single 'a'
    offer(8'h61, -1);
    offer(8'h00, -1);
    d_a = model_digest();
    chk("a_digest", digest_char, d_a);
    chk("a_ready", 64'(digest_ready), 64'd1);

    // Alphabet
    for (int i = 0; i < 26; i++) offer(8'(8'h61 + i), -1);
    offer(8'h00, -1);
    chk("alpha_ready", 64'(digest_ready), 64'd1);

    // New message after a published digest reloads IV
    offer(8'h61, -1);
    offer(8'h00, -1);
    chk("a_reload", digest_char, d_a);

    // Reset in the middle of a byte
    offer(8'h7A, 10);
    chk("abort_digest", digest_char, IV_C);
    chk("abort_nb", 64'(dut.next_byte), 64'd0);
    chk("abort_ready", 64'(digest_ready), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 60) rc = alnum[$urandom_range(0, 61)];
      else if (sel < 75) rc = 8'h00;
      else rc = 8'($urandom);
      offer(rc, -1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
